// File: rtl/dpr_pkg.sv
// dpr_pkg: shared types and constants for dual_port_responder
package dpr_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_e;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACKING
    } pst_e;

endpackage

// File: rtl/dpr_bank.sv
// dpr_bank: synchronous single-port RAM with registered read/write-through data, no array reset
module dpr_bank
    import dpr_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // one access per edge; a write returns its own data so the requester sees an echo
    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
        rdata <= we ? wdata : r_mem[addr];
    end

endmodule

// File: rtl/dual_port_responder.sv
// dual_port_responder: serialises two request ports onto one bank; DPR_RR_ARB_EN selects round-robin, else A-priority
module dual_port_responder
    import dpr_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqA,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] dataOutA,
    input  logic              reqB,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dataOutB,
    output logic              ackA,
    output logic              ackB,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    pst_e              r_st_a, r_st_b, w_nx_a, w_nx_b;
    logic              w_el_a, w_el_b, w_gnt_a, w_gnt_b, w_we, w_unused_hi;
    port_e             w_sel;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata, w_bank_q, r_hold_a, r_hold_b;

    // a port that is acknowledging this cycle sits out, and nothing is granted while in reset
    assign w_el_a = reset && reqA && r_st_a != ACKING;
    assign w_el_b = reset && reqB && r_st_b != ACKING;

`ifdef DPR_RR_ARB_EN
    port_e r_ptr;

    assign w_gnt_a = w_el_a && (!w_el_b || r_ptr == PORT_A);

    // pointer hands the next conflict to whichever port was not just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ptr <= PORT_A;
        else if (busy) r_ptr <= w_gnt_a ? PORT_B : PORT_A;
    end
`else
    assign w_gnt_a = w_el_a;
`endif

    assign w_gnt_b     = w_el_b && !w_gnt_a;
    assign busy        = w_gnt_a || w_gnt_b;
    assign w_sel       = w_gnt_b ? PORT_B : PORT_A;
    assign w_we        = (w_gnt_a && weA) || (w_gnt_b && weB);
    assign w_addr      = w_sel == PORT_B ? addrB[AW-1:0] : addrA[AW-1:0];
    assign w_wdata     = w_sel == PORT_B ? dataOutB : dataOutA;
    assign w_unused_hi = ^{addrA[ADDR_W-1:AW], addrB[ADDR_W-1:AW]};

    dpr_bank #(.DEPTH(DEPTH)) u_bank (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_bank_q)
    );

    // per-port next state: granted ports acknowledge next cycle, ungranted requests wait
    always_comb begin
        w_nx_a = IDLE;
        w_nx_b = IDLE;
        if (w_gnt_a) w_nx_a = ACKING;
        else if (reqA) w_nx_a = PEND;
        if (w_gnt_b) w_nx_b = ACKING;
        else if (reqB) w_nx_b = PEND;
    end

    // per-port state register; reset drops pending and in-flight acknowledges at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st_a <= IDLE;
            r_st_b <= IDLE;
        end else begin
            r_st_a <= w_nx_a;
            r_st_b <= w_nx_b;
        end
    end

    // keep the last acknowledged data so rdata stays stable between acks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_a <= '0;
            r_hold_b <= '0;
        end else begin
            if (ackA) r_hold_a <= w_bank_q;
            if (ackB) r_hold_b <= w_bank_q;
        end
    end

    assign ackA   = r_st_a == ACKING;
    assign ackB   = r_st_b == ACKING;
    assign rdataA = ackA ? w_bank_q : r_hold_a;
    assign rdataB = ackB ? w_bank_q : r_hold_b;

endmodule

// File: tb/tb_dual_port_responder.sv
// tb_dual_port_responder: directed and randomized checks against a cycle reference model
module tb_dual_port_responder;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0, reset = 1'b0;
    logic        reqA = 1'b0, weA = 1'b0, reqB = 1'b0, weB = 1'b0;
    logic [15:0] addrA = '0, addrB = '0, dataOutA = '0, dataOutB = '0;
    logic        ackA, ackB, busy;
    logic [15:0] rdataA, rdataB;

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] m_mem [DEPTH];
    logic        m_ack [2];
    logic [15:0] m_rd [2];
    int          m_ptr;
    logic        m_busy, obs_busy;

    dual_port_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .reqA(reqA), .weA(weA), .addrA(addrA), .dataOutA(dataOutA),
        .reqB(reqB), .weB(weB), .addrB(addrB), .dataOutB(dataOutB),
        .ackA(ackA), .ackB(ackB), .rdataA(rdataA), .rdataB(rdataB), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_a(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        reqA = r; weA = w; addrA = a; dataOutA = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        reqB = r; weB = w; addrB = a; dataOutB = d;
    endtask

    task automatic model_reset();
        m_ack[0] = 1'b0; m_ack[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0; m_ptr = 0;
    endtask

    // which port the responder should serve, -1 for none
    function automatic int pick(input logic ea, input logic eb);
        if (ea && eb) begin
`ifdef DPR_RR_ARB_EN
            return m_ptr;
`else
            return 0;
`endif
        end
        if (ea) return 0;
        if (eb) return 1;
        return -1;
    endfunction

    // one clock: predict the grant from current inputs, sample busy, then apply the access to the model
    task automatic tick();
        int w, a;
        w = pick(reqA && !m_ack[0], reqB && !m_ack[1]);
        m_busy = w >= 0;
        #1 obs_busy = busy;
        @(posedge clk);
        m_ack[0] = w == 0;
        m_ack[1] = w == 1;
        if (w == 0) begin
            a = int'(addrA) % DEPTH;
            if (weA) m_mem[a] = dataOutA;
            m_rd[0] = m_mem[a];
            m_ptr = 1;
        end
        if (w == 1) begin
            a = int'(addrB) % DEPTH;
            if (weB) m_mem[a] = dataOutB;
            m_rd[1] = m_mem[a];
            m_ptr = 0;
        end
        #1;
    endtask

    // idle cycle, then a lone request; returns in the acknowledge cycle with req already dropped
    task automatic solo(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
        tick();
        if (p == 0) set_a(1, w, a, d); else set_b(1, w, a, d);
        tick();
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
    endtask

    task automatic agent(input int p);
        logic r, ack;
        logic [15:0] a, d;
        logic w;
        r   = p == 0 ? reqA : reqB;
        ack = m_ack[p];
        w   = 1'($urandom_range(0, 1));
        a   = {8'($urandom), 5'd0, 3'($urandom_range(0, 7))};
        d   = 16'($urandom);
        if (r && !ack) begin
            if ($urandom_range(0, 9) == 0) r = 1'b0;
            else return;
        end else r = $urandom_range(0, 1) == 1;
        if (p == 0) set_a(r, w, a, d); else set_b(r, w, a, d);
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        set_a(1, 1, 16'h0007, 16'hDEAD); set_b(1, 0, 16'h0007, '0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ackA !== 1'b0 || ackB !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b%b want 00", ackA, ackB); end
        n_cmp++; if (rdataA !== 16'h0 || rdataB !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 0000/0000", rdataA, rdataB); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
        reset = 1'b1;
    endtask

    task automatic test_prefill();
        int miss = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 1, 16'(i), 16'($urandom));
            tick();
            if (ackA !== 1'b1 || rdataA !== m_rd[0]) miss++;
            set_a(0, 0, '0, '0);
            tick();
        end
        n_cmp++; if (miss != 0) begin n_bad++; $display("FAIL prefill_acks got %0d bad write acks want 0", miss); end
    endtask

    task automatic test_basic();
        tick();
        set_a(1, 1, 16'h0000, 16'h0001);
        tick();
        n_cmp++; if (obs_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", obs_busy); end
        n_cmp++; if (ackA !== 1'b1 || rdataA !== 16'h0001) begin n_bad++; $display("FAIL basic_write got ack=%b rdata=%h want ack=1 rdata=0001", ackA, rdataA); end
        set_a(1, 0, 16'h0000, '0);
        tick();
        n_cmp++; if (ackA !== 1'b0 || obs_busy !== 1'b0) begin n_bad++; $display("FAIL basic_no_regrant got ack=%b busy=%b want 0/0", ackA, obs_busy); end
        tick();
        n_cmp++; if (ackA !== 1'b1 || rdataA !== 16'h0001) begin n_bad++; $display("FAIL basic_read got ack=%b rdata=%h want ack=1 rdata=0001", ackA, rdataA); end
        set_a(0, 0, '0, '0);
        tick();
        n_cmp++; if (ackA !== 1'b0 || rdataA !== 16'h0001) begin n_bad++; $display("FAIL basic_hold got ack=%b rdata=%h want ack=0 rdata=0001", ackA, rdataA); end
    endtask

    task automatic test_conflict();
        solo(1, 0, 16'd5, '0);
        tick();
        set_a(1, 1, 16'd32, 16'h0003); set_b(1, 1, 16'd48, 16'h0004);
        tick();
        n_cmp++; if (ackA !== 1'b1 || ackB !== 1'b0 || rdataA !== 16'h0003) begin n_bad++; $display("FAIL conflict_first got ackA=%b ackB=%b rdataA=%h want 1/0/0003", ackA, ackB, rdataA); end
        set_a(0, 0, '0, '0);
        tick();
        n_cmp++; if (ackA !== 1'b0 || ackB !== 1'b1 || rdataB !== 16'h0004) begin n_bad++; $display("FAIL conflict_second got ackA=%b ackB=%b rdataB=%h want 0/1/0004", ackA, ackB, rdataB); end
        solo(0, 0, 16'd32, '0);
        n_cmp++; if (ackA !== 1'b1 || rdataA !== 16'h0003) begin n_bad++; $display("FAIL conflict_rbA got ack=%b rdata=%h want 1/0003", ackA, rdataA); end
        solo(1, 0, 16'd48, '0);
        n_cmp++; if (ackB !== 1'b1 || rdataB !== 16'h0004) begin n_bad++; $display("FAIL conflict_rbB got ack=%b rdata=%h want 1/0004", ackB, rdataB); end
    endtask

    task automatic test_same_addr();
        tick();
        set_a(1, 1, 16'd64, 16'h0005); set_b(1, 0, 16'd64, '0);
        tick();
        n_cmp++; if (ackA !== 1'b1 || ackB !== 1'b0) begin n_bad++; $display("FAIL same_ptrA_first got ackA=%b ackB=%b want 1/0", ackA, ackB); end
        set_a(0, 0, '0, '0);
        tick();
        n_cmp++; if (ackB !== 1'b1 || rdataB !== 16'h0005) begin n_bad++; $display("FAIL same_ptrA_read got ack=%b rdata=%h want 1/0005", ackB, rdataB); end
        solo(0, 0, 16'd0, '0);
        tick();
        set_a(1, 1, 16'd64, 16'h0006); set_b(1, 0, 16'd64, '0);
        tick();
`ifdef DPR_RR_ARB_EN
        n_cmp++; if (ackB !== 1'b1 || ackA !== 1'b0 || rdataB !== 16'h0005) begin n_bad++; $display("FAIL same_ptrB_old got ackA=%b ackB=%b rdataB=%h want 0/1/0005", ackA, ackB, rdataB); end
        set_b(0, 0, '0, '0);
        tick();
        n_cmp++; if (ackA !== 1'b1 || rdataA !== 16'h0006) begin n_bad++; $display("FAIL same_ptrB_write got ack=%b rdata=%h want 1/0006", ackA, rdataA); end
`else
        n_cmp++; if (ackA !== 1'b1 || ackB !== 1'b0) begin n_bad++; $display("FAIL same_fixed_first got ackA=%b ackB=%b want 1/0", ackA, ackB); end
        set_a(0, 0, '0, '0);
        tick();
        n_cmp++; if (ackB !== 1'b1 || rdataB !== 16'h0006) begin n_bad++; $display("FAIL same_fixed_read got ack=%b rdata=%h want 1/0006", ackB, rdataB); end
`endif
        solo(1, 0, 16'd64, '0);
        n_cmp++; if (rdataB !== 16'h0006) begin n_bad++; $display("FAIL same_final got %h want 0006", rdataB); end
    endtask

    task automatic test_alias();
        solo(0, 1, 16'h0110, 16'h0002);
        n_cmp++; if (ackA !== 1'b1 || rdataA !== 16'h0002) begin n_bad++; $display("FAIL alias_write got ack=%b rdata=%h want 1/0002", ackA, rdataA); end
        solo(1, 0, 16'd16, '0);
        n_cmp++; if (ackB !== 1'b1 || rdataB !== 16'h0002) begin n_bad++; $display("FAIL alias_read16 got ack=%b rdata=%h want 1/0002", ackB, rdataB); end
        solo(0, 0, 16'hFF10, '0);
        n_cmp++; if (rdataA !== 16'h0002) begin n_bad++; $display("FAIL alias_readFF10 got %h want 0002", rdataA); end
    endtask

    task automatic test_back_to_back();
        logic prev_a = 1'b0;
        int bad_alt = 0, bad_model = 0;
        tick();
        set_a(1, 0, 16'(8'($urandom)), '0); set_b(1, 0, 16'(8'($urandom)), '0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if ((ackA ^ ackB) !== 1'b1 || (i > 0 && ackA === prev_a)) bad_alt++;
            if (ackA !== m_ack[0] || ackB !== m_ack[1] || rdataA !== m_rd[0] || rdataB !== m_rd[1]) bad_model++;
            prev_a = ackA;
            if (m_ack[0]) addrA = 16'(8'($urandom));
            if (m_ack[1]) addrB = 16'(8'($urandom));
        end
        n_cmp++; if (bad_alt != 0) begin n_bad++; $display("FAIL b2b_alternate got %0d non-alternating cycles want 0", bad_alt); end
        n_cmp++; if (bad_model != 0) begin n_bad++; $display("FAIL b2b_model got %0d cycles off model want 0", bad_model); end
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        set_a(1, 1, 16'd200, 16'h0BAD);
        tick();
        set_a(0, 0, '0, '0);
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (ackA !== 1'b0 || ackB !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_ctl got ackA=%b ackB=%b busy=%b want 000", ackA, ackB, busy); end
        n_cmp++; if (rdataA !== 16'h0 || rdataB !== 16'h0) begin n_bad++; $display("FAIL midreset_rdata got %h/%h want 0000/0000", rdataA, rdataB); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        solo(1, 0, 16'd200, '0);
        n_cmp++; if (ackB !== 1'b1 || rdataB !== 16'h0BAD) begin n_bad++; $display("FAIL midreset_kept got ack=%b rdata=%h want 1/0bad", ackB, rdataB); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            agent(0);
            agent(1);
            tick();
            n_cmp++; if (obs_busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, obs_busy, m_busy); end
            n_cmp++; if (ackA !== m_ack[0]) begin n_bad++; $display("FAIL rnd_ackA cyc %0d got %b want %b", i, ackA, m_ack[0]); end
            n_cmp++; if (ackB !== m_ack[1]) begin n_bad++; $display("FAIL rnd_ackB cyc %0d got %b want %b", i, ackB, m_ack[1]); end
            n_cmp++; if (rdataA !== m_rd[0]) begin n_bad++; $display("FAIL rnd_rdataA cyc %0d got %h want %h", i, rdataA, m_rd[0]); end
            n_cmp++; if (rdataB !== m_rd[1]) begin n_bad++; $display("FAIL rnd_rdataB cyc %0d got %h want %h", i, rdataB, m_rd[1]); end
        end
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0);
        tick();
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_basic();
        test_conflict();
        test_same_addr();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
